cp0_ctrl: RTL and testbench

- Parametrised next-generation MIPS coprocessor 0 for the multi-cycle CPU.
- Holds SR, Cause, EPC, PRId, Count and Compare, and raises the interrupt request to the controller.
- Additions over the current CP0:
  - configurable hardware interrupt line count;
  - synchronous exception entry with ExcCode and branch-delay (BD) capture;
  - ERET handling;
  - an internal Count/Compare timer that drives interrupt line IP7.

---
 rtl/cp0_pkg.sv | 23 ++
 rtl/cp0_timer.sv | 55 +++++
 rtl/cp0_ctrl.sv | 116 +++++++++++
 tb/tb_cp0_ctrl.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// Shared constants for the MIPS coprocessor 0: register numbers, exception codes
// and a helper that packs the status register read value.
package cp0_pkg;

    localparam logic [4:0] CP0_COUNT   = 5'd9;
    localparam logic [4:0] CP0_COMPARE = 5'd11;
    localparam logic [4:0] CP0_SR      = 5'd12;
    localparam logic [4:0] CP0_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_EPC     = 5'd14;
    localparam logic [4:0] CP0_PRID    = 5'd15;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    function automatic logic [31:0] pack_sr(input logic [5:0] im, input logic exl, input logic ie);
        return {16'b0, im, 8'b0, exl, ie};
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: prescaled free-running Count, Compare register and a
// sticky match flag that drives interrupt line IP7.
module cp0_timer
    import cp0_pkg::*;
#(
    parameter int COUNT_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] din,
    input  logic        count_wen,
    input  logic        compare_wen,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        timer_pend
);

    localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

    logic [PW-1:0] presc;
    logic          tick;
    logic [31:0]   count_inc;

    assign tick      = (presc == PW'(COUNT_DIV - 1));
    assign count_inc = count + 32'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            presc      <= '0;
            count      <= '0;
            compare    <= '0;
            timer_pend <= 1'b0;
        end else begin
            if (count_wen) begin
                count <= din;
                presc <= '0;
            end else if (tick) begin
                presc <= '0;
                count <= count_inc;
            end else begin
                presc <= presc + 1'b1;
            end

            // Only an increment landing on Compare raises the flag; a Compare
            // write in the same cycle wins and leaves it clear.
            if (compare_wen) begin
                compare    <= din;
                timer_pend <= 1'b0;
            end else if (!count_wen && tick && (count_inc == compare)) begin
                timer_pend <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cp0_ctrl.sv
// Coprocessor 0 top: SR/Cause/EPC state, exception entry and ERET sequencing,
// MFC0 read mux and the interrupt request to the controller.
module cp0_ctrl
    import cp0_pkg::*;
#(
    parameter int          NUM_HWINT = 5,
    parameter int          COUNT_DIV = 1,
    parameter logic [31:0] PRID_VAL  = 32'h0000_4A01
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [29:0]          pc_in,
    input  logic                 bd_in,
    input  logic [31:0]          din,
    input  logic [NUM_HWINT-1:0] hwint,
    input  logic [4:0]           sel,
    input  logic                 wen,
    input  logic                 exc_set,
    input  logic [4:0]           exc_code,
    input  logic                 eret,
    output logic                 int_req,
    output logic [29:0]          epc,
    output logic [31:0]          dout,
    output logic                 exl_out,
    output logic                 timer_irq
);

    logic [5:0]           im;
    logic                 exl;
    logic                 ie;
    logic                 bd;
    logic [4:0]           exc_code_r;
    logic [29:0]          epc_r;
    logic [NUM_HWINT-1:0] hw_q;
    logic [4:0]           hw_pad;
    logic [5:0]           ip;
    logic [31:0]          count;
    logic [31:0]          compare;
    logic                 timer_pend;
    logic                 wr;

    // An exception entry in the same cycle swallows any MTC0 write.
    assign wr = wen && !exc_set;

    cp0_timer #(
        .COUNT_DIV(COUNT_DIV)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .count_wen  (wr && (sel == CP0_COUNT)),
        .compare_wen(wr && (sel == CP0_COMPARE)),
        .count      (count),
        .compare    (compare),
        .timer_pend (timer_pend)
    );

    always_comb begin
        hw_pad                = '0;
        hw_pad[NUM_HWINT-1:0] = hw_q;
    end

    assign ip        = {timer_pend, hw_pad};
    assign int_req   = (|(ip & im)) && ie && !exl;
    assign epc       = epc_r;
    assign exl_out   = exl;
    assign timer_irq = timer_pend;

    always_comb begin
        case (sel)
            CP0_COUNT:   dout = count;
            CP0_COMPARE: dout = compare;
            CP0_SR:      dout = pack_sr(im, exl, ie);
            CP0_CAUSE:   dout = {bd, 15'b0, ip, 3'b0, exc_code_r, 2'b0};
            CP0_EPC:     dout = {epc_r, 2'b00};
            CP0_PRID:    dout = PRID_VAL;
            default:     dout = 32'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            im         <= '0;
            exl        <= 1'b0;
            ie         <= 1'b0;
            bd         <= 1'b0;
            exc_code_r <= '0;
            epc_r      <= '0;
            hw_q       <= '0;
        end else begin
            hw_q <= hwint;
            if (exc_set) begin
                exc_code_r <= exc_code;
                exl        <= 1'b1;
                // Nested entries keep the original return address.
                if (!exl) begin
                    epc_r <= bd_in ? (pc_in - 30'd1) : pc_in;
                    bd    <= bd_in;
                end
            end else begin
                if (wen && (sel == CP0_SR)) begin
                    im  <= din[15:10];
                    exl <= din[1];
                    ie  <= din[0];
                end
                if (wen && (sel == CP0_EPC)) begin
                    epc_r <= din[31:2];
                end
                if (eret) begin
                    exl <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cp0_ctrl.sv
// Self-checking bench for cp0_ctrl: directed scenarios plus randomized traffic
// against a behavioural CP0 model.
module tb_cp0_ctrl;

    localparam int          NUM_HWINT = 5;
    localparam int          COUNT_DIV = 1;
    localparam logic [31:0] PRID_VAL  = 32'h0000_4A01;

    logic                 clk;
    logic                 rst;
    logic [29:0]          pc_in;
    logic                 bd_in;
    logic [31:0]          din;
    logic [NUM_HWINT-1:0] hwint;
    logic [4:0]           sel;
    logic                 wen;
    logic                 exc_set;
    logic [4:0]           exc_code;
    logic                 eret;
    logic                 int_req;
    logic [29:0]          epc;
    logic [31:0]          dout;
    logic                 exl_out;
    logic                 timer_irq;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q[$];

    // behavioural model state
    logic [31:0]          m_count, m_compare;
    int                   m_presc;
    logic                 m_pend;
    logic [5:0]           m_im;
    logic                 m_exl, m_ie, m_bd;
    logic [4:0]           m_code;
    logic [29:0]          m_epc;
    logic [NUM_HWINT-1:0] m_hw;

    cp0_ctrl #(
        .NUM_HWINT(NUM_HWINT),
        .COUNT_DIV(COUNT_DIV),
        .PRID_VAL (PRID_VAL)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pc_in    (pc_in),
        .bd_in    (bd_in),
        .din      (din),
        .hwint    (hwint),
        .sel      (sel),
        .wen      (wen),
        .exc_set  (exc_set),
        .exc_code (exc_code),
        .eret     (eret),
        .int_req  (int_req),
        .epc      (epc),
        .dout     (dout),
        .exl_out  (exl_out),
        .timer_irq(timer_irq)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model ----------------
    function automatic logic [5:0] m_ip();
        logic [5:0] v;
        v = 6'b0;
        for (int i = 0; i < NUM_HWINT; i++) v[i] = m_hw[i];
        v[5] = m_pend;
        return v;
    endfunction

    function automatic logic m_int_req();
        return ((m_ip() & m_im) != 6'b0) && m_ie && !m_exl;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] s);
        case (s)
            5'd9:    return m_count;
            5'd11:   return m_compare;
            5'd12:   return {16'b0, m_im, 8'b0, m_exl, m_ie};
            5'd13:   return {m_bd, 15'b0, m_ip(), 3'b0, m_code, 2'b0};
            5'd14:   return {m_epc, 2'b00};
            5'd15:   return PRID_VAL;
            default: return 32'b0;
        endcase
    endfunction

    function automatic void model_step();
        logic wr;
        logic incr;
        if (rst) begin
            m_count = 0; m_compare = 0; m_presc = 0; m_pend = 0;
            m_im = 0; m_exl = 0; m_ie = 0; m_bd = 0; m_code = 0; m_epc = 0; m_hw = 0;
            return;
        end
        wr   = wen && !exc_set;
        incr = 1'b0;
        if (wr && sel == 5'd9) begin
            m_count = din;
            m_presc = 0;
        end else begin
            m_presc = m_presc + 1;
            if (m_presc == COUNT_DIV) begin
                m_presc = 0;
                m_count = m_count + 32'd1;
                incr    = 1'b1;
            end
        end
        if (wr && sel == 5'd11) begin
            m_compare = din;
            m_pend    = 1'b0;
        end else if (incr && m_count == m_compare) begin
            m_pend = 1'b1;
        end
        m_hw = hwint;
        if (exc_set) begin
            if (!m_exl) begin
                m_epc = bd_in ? pc_in - 30'd1 : pc_in;
                m_bd  = bd_in;
            end
            m_code = exc_code;
            m_exl  = 1'b1;
        end else begin
            if (wen && sel == 5'd12) begin
                m_im  = din[15:10];
                m_exl = din[1];
                m_ie  = din[0];
            end
            if (wen && sel == 5'd14) m_epc = din[31:2];
            if (eret) m_exl = 1'b0;
        end
    endfunction

    // ---------------- drivers ----------------
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        rst = 0; wen = 0; exc_set = 0; eret = 0;
    endtask

    task automatic write_reg(input logic [4:0] s, input logic [31:0] d);
        wen = 1; sel = s; din = d;
        tick();
        wen = 0;
    endtask

    task automatic peek(input logic [4:0] s);
        sel = s;
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1;
        tick();
        rst = 0;
        checks += 4;
        if (int_req !== 1'b0)   begin failures++; $display("FAIL reset_int_req got=%b exp=0", int_req); end
        if (epc !== 30'd0)      begin failures++; $display("FAIL reset_epc got=%h exp=0", epc); end
        if (exl_out !== 1'b0)   begin failures++; $display("FAIL reset_exl got=%b exp=0", exl_out); end
        if (timer_irq !== 1'b0) begin failures++; $display("FAIL reset_timer_irq got=%b exp=0", timer_irq); end
        peek(5'd15);
        checks++;
        if (dout !== PRID_VAL) begin failures++; $display("FAIL reset_prid got=%h exp=%h", dout, PRID_VAL); end
        peek(5'd9);
        checks++;
        if (dout !== 32'd0) begin failures++; $display("FAIL reset_count got=%h exp=0", dout); end
    endtask

    task automatic test_hwint();
        hwint = '0;
        write_reg(5'd12, 32'h0000_8401);
        peek(5'd12);
        checks++;
        if (dout !== 32'h0000_8401) begin failures++; $display("FAIL sr_read got=%h exp=00008401", dout); end
        hwint = 5'b00001;
        #1;
        checks++;
        if (int_req !== 1'b0) begin failures++; $display("FAIL hwint_latency got=%b exp=0", int_req); end
        tick();
        checks++;
        if (int_req !== 1'b1) begin failures++; $display("FAIL hwint_int_req got=%b exp=1", int_req); end
        peek(5'd13);
        checks++;
        if (dout !== 32'h0000_0400) begin failures++; $display("FAIL cause_ip10 got=%h exp=00000400", dout); end
    endtask

    task automatic test_exception();
        pc_in = 30'h0000_0C10; bd_in = 1; exc_code = 5'd0; exc_set = 1;
        tick();
        exc_set = 0;
        checks += 3;
        if (epc !== 30'h0000_0C0F) begin failures++; $display("FAIL exc_epc got=%h exp=00000c0f", epc); end
        if (exl_out !== 1'b1)      begin failures++; $display("FAIL exc_exl got=%b exp=1", exl_out); end
        if (int_req !== 1'b0)      begin failures++; $display("FAIL exc_int_masked got=%b exp=0", int_req); end
        peek(5'd13);
        checks++;
        if (dout[31] !== 1'b1) begin failures++; $display("FAIL exc_bd got=%b exp=1", dout[31]); end
        pc_in = 30'h0000_0123; bd_in = 0; exc_code = 5'd12; exc_set = 1;
        tick();
        exc_set = 0;
        checks++;
        if (epc !== 30'h0000_0C0F) begin failures++; $display("FAIL nested_epc got=%h exp=00000c0f", epc); end
        peek(5'd13);
        checks += 2;
        if (dout[6:2] !== 5'd12) begin failures++; $display("FAIL nested_code got=%0d exp=12", dout[6:2]); end
        if (dout[31] !== 1'b1)   begin failures++; $display("FAIL nested_bd got=%b exp=1", dout[31]); end
        eret = 1;
        tick();
        eret = 0;
        checks += 2;
        if (exl_out !== 1'b0) begin failures++; $display("FAIL eret_exl got=%b exp=0", exl_out); end
        if (int_req !== 1'b1) begin failures++; $display("FAIL eret_int_req got=%b exp=1", int_req); end
        hwint = '0;
        tick();
    endtask

    task automatic test_timer_wrap();
        write_reg(5'd9, 32'hFFFF_FFFE);
        write_reg(5'd11, 32'h0000_0001);
        peek(5'd9);
        checks += 2;
        if (dout !== 32'hFFFF_FFFF) begin failures++; $display("FAIL wrap_count_ff got=%h exp=ffffffff", dout); end
        if (timer_irq !== 1'b0)     begin failures++; $display("FAIL wrap_irq_early got=%b exp=0", timer_irq); end
        tick();
        peek(5'd9);
        checks += 2;
        if (dout !== 32'd0)     begin failures++; $display("FAIL wrap_count_0 got=%h exp=0", dout); end
        if (timer_irq !== 1'b0) begin failures++; $display("FAIL wrap_irq_at0 got=%b exp=0", timer_irq); end
        tick();
        peek(5'd9);
        checks += 2;
        if (dout !== 32'd1)     begin failures++; $display("FAIL wrap_count_1 got=%h exp=1", dout); end
        if (timer_irq !== 1'b1) begin failures++; $display("FAIL wrap_irq_match got=%b exp=1", timer_irq); end
        tick();
        checks++;
        if (timer_irq !== 1'b1) begin failures++; $display("FAIL irq_sticky got=%b exp=1", timer_irq); end
        write_reg(5'd11, 32'h0000_1000);
        checks++;
        if (timer_irq !== 1'b0) begin failures++; $display("FAIL compare_clear got=%b exp=0", timer_irq); end
        // Compare write coinciding with a match must leave the flag clear
        write_reg(5'd11, 32'd51);
        write_reg(5'd9, 32'd50);
        write_reg(5'd11, 32'd200);
        checks++;
        if (timer_irq !== 1'b0) begin failures++; $display("FAIL compare_vs_match got=%b exp=0", timer_irq); end
    endtask

    task automatic test_count_write_eq();
        int bad;
        write_reg(5'd11, 32'd5);
        write_reg(5'd9, 32'd5);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (timer_irq !== 1'b0) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL count_write_eq got=%0d irq cycles exp=0", bad); end
    endtask

    task automatic test_back_to_back_priority();
        write_reg(5'd12, 32'h0000_8401);
        exc_set = 1; exc_code = 5'd4; pc_in = 30'h40; bd_in = 0;
        wen = 1; sel = 5'd12; din = 32'h0;
        tick();
        exc_set = 0; wen = 0;
        peek(5'd12);
        checks += 2;
        if (exl_out !== 1'b1)       begin failures++; $display("FAIL exc_wen_exl got=%b exp=1", exl_out); end
        if (dout !== 32'h0000_8403) begin failures++; $display("FAIL exc_wen_sr got=%h exp=00008403", dout); end
        eret = 1; wen = 1; sel = 5'd12; din = 32'h3;
        tick();
        eret = 0; wen = 0;
        peek(5'd12);
        checks += 2;
        if (exl_out !== 1'b0)       begin failures++; $display("FAIL eret_wen_exl got=%b exp=0", exl_out); end
        if (dout !== 32'h0000_0001) begin failures++; $display("FAIL eret_wen_sr got=%h exp=00000001", dout); end
    endtask

    task automatic test_reset_mid();
        write_reg(5'd9, 32'd100);
        write_reg(5'd11, 32'd103);
        tick();
        tick();
        exc_set = 1; exc_code = 5'd8; pc_in = 30'h77; bd_in = 0;
        tick();
        exc_set = 0;
        checks += 2;
        if (timer_irq !== 1'b1) begin failures++; $display("FAIL pre_rst_irq got=%b exp=1", timer_irq); end
        if (exl_out !== 1'b1)   begin failures++; $display("FAIL pre_rst_exl got=%b exp=1", exl_out); end
        rst = 1;
        tick();
        rst = 0;
        checks += 4;
        if (int_req !== 1'b0)   begin failures++; $display("FAIL mid_rst_int_req got=%b exp=0", int_req); end
        if (epc !== 30'd0)      begin failures++; $display("FAIL mid_rst_epc got=%h exp=0", epc); end
        if (exl_out !== 1'b0)   begin failures++; $display("FAIL mid_rst_exl got=%b exp=0", exl_out); end
        if (timer_irq !== 1'b0) begin failures++; $display("FAIL mid_rst_irq got=%b exp=0", timer_irq); end
        peek(5'd9);
        checks++;
        if (dout !== 32'd0) begin failures++; $display("FAIL mid_rst_count got=%h exp=0", dout); end
        peek(5'd15);
        checks++;
        if (dout !== PRID_VAL) begin failures++; $display("FAIL mid_rst_prid got=%h exp=%h", dout, PRID_VAL); end
        peek(5'd11);
        checks++;
        if (dout !== 32'd0) begin failures++; $display("FAIL mid_rst_compare got=%h exp=0", dout); end
    endtask

    task automatic test_random();
        logic [4:0]  sels[7];
        logic [31:0] exp_v;
        sels = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd0};
        for (int i = 0; i < 600; i++) begin
            rst      = ($urandom_range(0, 63) == 0);
            exc_set  = ($urandom_range(0, 11) == 0);
            eret     = ($urandom_range(0, 11) == 0);
            wen      = ($urandom_range(0, 2) == 0);
            sel      = sels[$urandom_range(0, 6)];
            if (sel == 5'd0) sel = 5'($urandom_range(0, 31));
            din      = $urandom;
            if (sel == 5'd11 && $urandom_range(0, 1) == 1) din = m_count + 32'($urandom_range(1, 6));
            if (sel == 5'd12 && $urandom_range(0, 1) == 1) din[1] = 1'b0;
            pc_in    = 30'($urandom);
            bd_in    = 1'($urandom_range(0, 1));
            exc_code = 5'($urandom_range(0, 31));
            hwint    = NUM_HWINT'($urandom);
            tick();
            drive_idle();
            checks += 4;
            if (int_req !== m_int_req()) begin failures++; $display("FAIL rnd_int_req i=%0d got=%b exp=%b", i, int_req, m_int_req()); end
            if (epc !== m_epc)           begin failures++; $display("FAIL rnd_epc i=%0d got=%h exp=%h", i, epc, m_epc); end
            if (exl_out !== m_exl)       begin failures++; $display("FAIL rnd_exl i=%0d got=%b exp=%b", i, exl_out, m_exl); end
            if (timer_irq !== m_pend)    begin failures++; $display("FAIL rnd_timer_irq i=%0d got=%b exp=%b", i, timer_irq, m_pend); end
            sel = sels[$urandom_range(0, 5)];
            exp_q.push_back(m_read(sel));
            #1;
            exp_v = exp_q.pop_front();
            checks++;
            if (dout !== exp_v) begin failures++; $display("FAIL rnd_dout i=%0d sel=%0d got=%h exp=%h", i, sel, dout, exp_v); end
        end
    endtask

    initial begin
        drive_idle();
        pc_in = '0; bd_in = 0; din = '0; hwint = '0; sel = '0; exc_code = '0;
        m_count = 0; m_compare = 0; m_presc = 0; m_pend = 0;
        m_im = 0; m_exl = 0; m_ie = 0; m_bd = 0; m_code = 0; m_epc = 0; m_hw = 0;
        @(negedge clk);
        test_reset();
        test_hwint();
        test_exception();
        test_timer_wrap();
        test_count_write_eq();
        test_back_to_back_priority();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
